spi_command_rx: RTL
===================

SPI_COMMAND_RX -- requirements
Module: spi_command_rx

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the byte FIFO depth; it is a power of two, minimum 4.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer flops on each SPI input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port spi_sck, input, 1 bit: SPI clock from the CPU, asynchronous to clk.
REQ-006 The block SHALL have port spi_cs_n, input, 1 bit: SPI chip select, active low, asynchronous.
REQ-007 The block SHALL have port spi_mosi, input, 1 bit: SPI data from the CPU, asynchronous.
REQ-008 The block SHALL have port command_rddata, output, 8 bits: FIFO read data, registered.
REQ-009 The block SHALL have port command_pull, input, 1 bit: read request from the command decoder.
REQ-010 The block SHALL have port command_empty, output, 1 bit: high when the FIFO holds no bytes.
REQ-011 The block SHALL have port command_overflow, output, 1 bit: sticky flag, high once a received byte has been dropped.

Function
REQ-012 spi_sck, spi_cs_n and spi_mosi SHALL each pass through SYNC_STAGES flops; all logic uses only the synchronized copies.
REQ-013 SPI mode SHALL be mode 0, MSB first; the supported spi_sck frequency is at most clk/4.
REQ-014 An SCK rising edge SHALL be detected when synchronized sck is 1 and its previous-cycle value is 0; at that cycle, synchronized mosi shifts into the 8-bit shift register LSB and the 3-bit bit counter increments.
REQ-015 Edges SHALL be ignored while synchronized cs_n is high; a rising or high cs_n clears the bit counter and discards any partial byte.
REQ-016 On the 8th detected edge (bit counter 7 -> 0), the completed byte SHALL be written to the FIFO at that same clock edge, provided the FIFO is not full.
REQ-017 If the FIFO is full at that edge, the byte SHALL be dropped, FIFO contents SHALL be unchanged, and command_overflow SHALL set and stay high until rst.
REQ-018 The FIFO SHALL use write pointer, read pointer and count registers of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-019 command_empty SHALL equal (count == 0), decoded from registered count with no combinational path from inputs.
REQ-020 Full SHALL equal (count == DEPTH); it is internal only.
REQ-021 A pull accepted at edge T (command_pull high and command_empty low) SHALL present the oldest byte on command_rddata from T+1, advance the read pointer, and hold that value until the next accepted pull.
REQ-022 command_pull while command_empty is high SHALL be ignored: no pointer change, command_rddata unchanged, no error flag.
REQ-023 A write and an accepted pull in the same cycle SHALL both take effect, leaving count unchanged.
REQ-024 A write into the empty FIFO SHALL not be readable until command_empty falls, one cycle after the write edge; there is no fall-through.
REQ-025 A write to a full FIFO coinciding with an accepted pull SHALL succeed, with no overflow.
REQ-026 End-to-end latency SHALL be SYNC_STAGES+1 clk cycles from the 8th raw SCK rise to command_empty falling, excluding metastability resolution.

Reset
REQ-027 When rst is high, the block SHALL immediately clear the pointers, count, bit counter, shift register, command_rddata (8'h00) and command_overflow (0), set command_empty to 1, and preset the synchronizers (sck 0, cs_n 1, mosi 0).
REQ-028 Reset asserted mid-byte SHALL discard the partial byte; after release, reception SHALL restart at bit 0 only after cs_n is seen high and then low again.
REQ-029 FIFO storage array contents need not be reset.

Verification
REQ-030 Scenario: cs_n low, send 8'hA5 at clk/8 -> command_empty falls SYNC_STAGES+1 cycles after the 8th SCK rise; pull -> command_rddata = 8'hA5 next cycle; command_empty high again.
REQ-031 Scenario: send 16 bytes 8'h00..8'h0F with no pulls, then 8'h10 -> 8'h10 dropped and command_overflow = 1; 16 pulls return 8'h00..8'h0F in order.
REQ-032 Scenario: send 5 bits, raise cs_n, lower it, send 8'h3C -> exactly one byte, 8'h3C, is received.
REQ-033 Scenario: FIFO full, and a pull coincides with completion of byte 8'h77 -> count stays 16, no overflow, 8'h77 emerges last.
REQ-034 Scenario: pull held high continuously while empty, then one byte 8'h5A arrives -> command_rddata changes only once, to 8'h5A, and read pointer advances by exactly 1.
REQ-035 Scenario: rst pulsed after 3 bytes are queued and mid-4th byte -> command_empty = 1, command_rddata = 8'h00, command_overflow = 0 immediately; the next clean byte after a cs_n cycle is received correctly.

Source files
------------

// File: rtl/spi_command_rx.sv
// ============================================================================
// Module   : spi_command_rx
// Brief    : SPI mode-0 byte receiver that pushes completed bytes into a FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_command_rx #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic [7:0] command_rddata,
    input  logic       command_pull,
    output logic       command_empty,
    output logic       command_overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_FW = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic [c_FW-1:0]        r_flush;
    logic                   r_armed;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [c_CW-1:0]        r_wr_ptr;
    logic [c_CW-1:0]        r_rd_ptr;
    logic [c_CW-1:0]        r_count;
    logic [7:0]             r_mem [DEPTH];
    logic [7:0]             r_rddata;
    logic                   r_overflow;

    logic       w_sck;
    logic       w_cs_n;
    logic       w_mosi;
    logic       w_edge;
    logic       w_wr_req;
    logic       w_full;
    logic       w_pull_ok;
    logic       w_wr_ok;
    logic [7:0] w_byte;

    assign w_sck     = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_edge    = w_sck & ~r_sck_prev & ~w_cs_n & r_armed;
    assign w_byte    = {r_shift[6:0], w_mosi};
    assign w_wr_req  = w_edge && (r_bit_cnt == 3'd7);
    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_pull_ok = command_pull && !command_empty;
    assign w_wr_ok   = w_wr_req && (!w_full || w_pull_ok);

    assign command_empty    = (r_count == '0);
    assign command_rddata   = r_rddata;
    assign command_overflow = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
        end else begin
            r_sck_sync[0]  <= spi_sck;
            r_cs_sync[0]   <= spi_cs_n;
            r_mosi_sync[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sck_sync[i]  <= r_sck_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
        end
    end

    // The preset cs_n=1 in the synchronizer is not a real deselect: arming waits
    // until the chain carries genuine samples and one of them shows cs_n high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_prev <= 1'b0;
            r_flush    <= '0;
            r_armed    <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            r_sck_prev <= w_sck;
            if (r_flush != c_FW'(SYNC_STAGES)) begin
                r_flush <= r_flush + c_FW'(1);
            end else if (w_cs_n) begin
                r_armed <= 1'b1;
            end
            if (w_cs_n || !r_armed) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'h00;
            end else if (w_edge) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= w_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rddata   <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_CW'(DEPTH - 1)) ? '0 : r_wr_ptr + c_CW'(1);
            end
            if (w_pull_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_CW'(DEPTH - 1)) ? '0 : r_rd_ptr + c_CW'(1);
                r_rddata <= r_mem[r_rd_ptr[c_AW-1:0]];
            end
            if (w_wr_ok && !w_pull_ok) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_wr_ok && w_pull_ok) begin
                r_count <= r_count - c_CW'(1);
            end
            if (w_wr_req && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
